// File: rtl/input_fifo_array_if.sv
// Input FIFO array bus: host push/pop strobes, register writes, array data.
// master = host side, slave = FIFO array side.
interface input_fifo_array_if #(
  parameter int LANES          = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR       = 8,
  parameter int REG_DATA_WIDTH = 32
);
  logic [LANES-1:0]            WR_EN;
  logic [DATA_WIDTH-1:0]       din;
  logic                        RD_EN;
  logic                        col_en;
  logic                        reg_en;
  logic [REG_ADDR-1:0]         a_reg;
  logic [REG_DATA_WIDTH-1:0]   d_reg;
  logic [LANES*DATA_WIDTH-1:0] RD_DATA;
  logic                        rd_valid;
  logic                        full;
  logic                        afull;
  logic                        empty;
  logic                        overflow;
  logic                        underflow;
  logic [$clog2(LANES+1)-1:0]  matrix_act;

  modport master (
    output WR_EN, din, RD_EN, col_en,
    output reg_en, a_reg, d_reg,
    input  RD_DATA, rd_valid, full, afull,
    input  empty, overflow, underflow, matrix_act
  );

  modport slave (
    input  WR_EN, din, RD_EN, col_en,
    input  reg_en, a_reg, d_reg,
    output RD_DATA, rd_valid, full, afull,
    output empty, overflow, underflow, matrix_act
  );
endinterface

// File: rtl/input_fifo_array.sv
// Multi-lane input staging FIFO: per-lane circular buffers, masked pop.
// Ports: CLK, rst (sync, active high), bus (input_fifo_array_if.slave).
module input_fifo_array #(
  parameter int LANES          = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int AFULL_LEVEL    = 3,
  parameter int REG_ADDR       = 8,
  parameter int REG_DATA_WIDTH = 32,
  parameter logic [REG_ADDR-1:0] MASK_ADDR = 'h01,
  parameter logic [REG_ADDR-1:0] CTRL_ADDR = 'h02
) (
  input logic CLK,
  input logic rst,
  input_fifo_array_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(LANES + 1);
  localparam int DW  = DATA_WIDTH;

  logic [LANES-1:0]    mask_q, mask_d;
  logic [LANES-1:0]    even, eff;
  logic [PW-1:0]       wr_q [LANES];
  logic [PW-1:0]       wr_d [LANES];
  logic [PW-1:0]       rd_q [LANES];
  logic [PW-1:0]       rd_d [LANES];
  logic [PW-1:0]       occ  [LANES];
  logic [DW-1:0]       mem_q [LANES][DEPTH];
  logic [LANES*DW-1:0] rdata_q, rdata_d;
  logic                rv_q, rv_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic [LANES-1:0]    l_full, l_empty, l_af;
  logic [LANES-1:0]    push;
  logic                full, afull, empty;
  logic                pop, flush, clr;
  logic                ctrl_wr, mask_wr;
  logic                ovf_ev, udf_ev;
  logic [CW-1:0]       act;

  always_comb begin
    even = '0;
    for (int i = 0; i < LANES; i++)
      even[i] = (i % 2 == 0);
    eff = mask_q & (bus.col_en ? even : '1);
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      occ[i]     = wr_q[i] - rd_q[i];
      l_full[i]  = occ[i] == PW'(DEPTH);
      l_empty[i] = occ[i] == '0;
      l_af[i]    = occ[i] >= PW'(AFULL_LEVEL);
    end
  end

  // Lanes outside eff count as full so they never hold full low.
  assign full  = &(l_full | ~eff);
  assign afull = |(l_af & eff);
  assign empty = |(l_empty & eff);

  always_comb begin
    act = '0;
    for (int i = 0; i < LANES; i++)
      act = act + CW'(eff[i]);
  end

  assign ctrl_wr = bus.reg_en && (bus.a_reg == CTRL_ADDR);
  assign mask_wr = bus.reg_en && (bus.a_reg == MASK_ADDR)
                   && (|bus.d_reg[LANES-1:0]);
  assign flush   = ctrl_wr && bus.d_reg[0];
  assign clr     = ctrl_wr && bus.d_reg[1];
  assign pop     = bus.RD_EN && !empty;
  assign udf_ev  = bus.RD_EN && empty;

  // A full lane still accepts when the pop frees a slot this cycle.
  assign push   = bus.WR_EN & eff & (~l_full | {LANES{pop}});
  assign ovf_ev = (|(bus.WR_EN & eff & l_full)) && !pop;

  always_comb begin
    mask_d  = mask_wr ? bus.d_reg[LANES-1:0] : mask_q;
    ovf_d   = ovf_ev | (ovf_q & ~clr);
    udf_d   = udf_ev | (udf_q & ~clr);
    rv_d    = pop && !flush;
    rdata_d = rdata_q;
    for (int i = 0; i < LANES; i++) begin
      if (rv_d)
        rdata_d[i*DW +: DW] = eff[i] ? mem_q[i][rd_q[i][AW-1:0]] : '0;
      wr_d[i] = flush ? '0 : wr_q[i] + PW'(push[i]);
      rd_d[i] = flush ? '0 : rd_q[i] + PW'(pop && eff[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      mask_q  <= '1;
      rdata_q <= '0;
      rv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wr_q[i] <= '0;
        rd_q[i] <= '0;
      end
    end else begin
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      for (int i = 0; i < LANES; i++) begin
        wr_q[i] <= wr_d[i];
        rd_q[i] <= rd_d[i];
      end
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < LANES; i++)
      if (push[i] && !flush)
        mem_q[i][wr_q[i][AW-1:0]] <= bus.din;
  end

  assign bus.RD_DATA    = rdata_q;
  assign bus.rd_valid   = rv_q;
  assign bus.full       = full;
  assign bus.afull      = afull;
  assign bus.empty      = empty;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;
  assign bus.matrix_act = act;
endmodule
